// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the bus-datapath control sequencer: opcodes, ALU codes,
// sequencer states and the one-hot positions of the non-GPR bus agents.
package cpu_ctrl_pkg;

    localparam int NUM_GPR   = 8;
    localparam int GPR_IDX_W = $clog2(NUM_GPR);
    localparam int CTRL_W    = 20;
    localparam int IMM_W     = 16;
    localparam int CODE_W    = 23;

    localparam int IDX_G   = 9;
    localparam int IDX_A   = 10;
    localparam int IDX_IMM = 10;

    typedef enum logic [2:0] {
        OP_MV   = 3'd0,
        OP_MVI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_HALT
    } state_t;

    function automatic logic isAluOp(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic alu_op_t aluCode(input opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Moore decode of sequencer state plus latched instruction into datapath
// register enables, bus drivers, ALU/immediate code and the done pulse.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t                i_state,
    input  opcode_t               i_op,
    input  logic [GPR_IDX_W-1:0]  i_rx,
    input  logic [GPR_IDX_W-1:0]  i_ry,
    input  logic [IMM_W-1:0]      i_imm,
    output logic [CTRL_W-1:0]     o_r_en,
    output logic [CTRL_W-1:0]     o_tri,
    output logic [CODE_W-1:0]     o_code,
    output logic                  o_done
);

    // Each busy state sets exactly one driver bit, so the bus is never contended.
    always_comb begin
        o_r_en = '0;
        o_tri  = '0;
        o_code = '0;
        o_done = 1'b0;
        case (i_state)
            ST_T1: begin
                if (i_op == OP_MV) begin
                    o_tri[i_ry]  = 1'b1;
                    o_r_en[i_rx] = 1'b1;
                    o_done       = 1'b1;
                end else if (i_op == OP_MVI) begin
                    o_tri[IDX_IMM]     = 1'b1;
                    o_code[IMM_W-1:0]  = i_imm;
                    o_r_en[i_rx]       = 1'b1;
                    o_done             = 1'b1;
                end else if (isAluOp(i_op)) begin
                    o_tri[i_rx]   = 1'b1;
                    o_r_en[IDX_A] = 1'b1;
                end
            end
            ST_T2: begin
                if (isAluOp(i_op)) begin
                    o_tri[i_ry]   = 1'b1;
                    o_r_en[IDX_G] = 1'b1;
                    o_code[22:20] = aluCode(i_op);
                end
            end
            ST_T3: begin
                if (isAluOp(i_op)) begin
                    o_tri[IDX_G] = 1'b1;
                    o_r_en[i_rx] = 1'b1;
                    o_done       = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction per valid/ready handshake,
// holds it while stepping IDLE->T1(->T2->T3)->IDLE, and parks in HALT until reset.
module cpu_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [2:0]            instr_op,
    input  logic [GPR_IDX_W-1:0]  instr_rx,
    input  logic [GPR_IDX_W-1:0]  instr_ry,
    input  logic [IMM_W-1:0]      instr_imm,
    output logic                  instr_ready,
    output logic [CTRL_W-1:0]     r_en_OH,
    output logic [CTRL_W-1:0]     tri_controller_OH,
    output logic [CODE_W-1:0]     code,
    output logic                  done,
    output logic                  halted
);

    state_t                r_state;
    opcode_t               r_op;
    logic [GPR_IDX_W-1:0]  r_rx;
    logic [GPR_IDX_W-1:0]  r_ry;
    logic [IMM_W-1:0]      r_imm;
    opcode_t               w_newOp;

    assign w_newOp = opcode_t'(instr_op);

    // Instructions are latched only from IDLE; valid while busy is simply not looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MV;
            r_rx    <= '0;
            r_ry    <= '0;
            r_imm   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_op    <= w_newOp;
                        r_rx    <= instr_rx;
                        r_ry    <= instr_ry;
                        r_imm   <= instr_imm;
                        r_state <= (w_newOp == OP_HALT) ? ST_HALT : ST_T1;
                    end
                end
                ST_T1:   r_state <= isAluOp(r_op) ? ST_T2 : ST_IDLE;
                ST_T2:   r_state <= ST_T3;
                ST_T3:   r_state <= ST_IDLE;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign halted      = (r_state == ST_HALT);

    cpu_ctrl_decode u_decode (
        .i_state (r_state),
        .i_op    (r_op),
        .i_rx    (r_rx),
        .i_ry    (r_ry),
        .i_imm   (r_imm),
        .o_r_en  (r_en_OH),
        .o_tri   (tri_controller_OH),
        .o_code  (code),
        .o_done  (done)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer driving a small behavioural 16-bit bus datapath; results
// are compared against constant tables and a register-file reference model.
module tb_cpu_sequencer;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [2:0]  instr_op = '0;
    logic [2:0]  instr_rx = '0;
    logic [2:0]  instr_ry = '0;
    logic [15:0] instr_imm = '0;
    logic        instr_ready;
    logic [19:0] r_en_OH;
    logic [19:0] tri_controller_OH;
    logic [22:0] code;
    logic        done;
    logic        halted;

    int vecCount = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_valid       (instr_valid),
        .instr_op          (instr_op),
        .instr_rx          (instr_rx),
        .instr_ry          (instr_ry),
        .instr_imm         (instr_imm),
        .instr_ready       (instr_ready),
        .r_en_OH           (r_en_OH),
        .tri_controller_OH (tri_controller_OH),
        .code              (code),
        .done              (done),
        .halted            (halted)
    );

    // The datapath the sequencer controls: eight GPRs, A, G, ALU and immediate driver.
    logic [15:0] dpR [8] = '{default: 16'h0};
    logic [15:0] dpA = 16'h0;
    logic [15:0] dpG = 16'h0;
    logic [15:0] busVal;

    function automatic logic [15:0] dpAlu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] sel);
        case (sel)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 16'h0;
        endcase
    endfunction

    always_comb begin
        busVal = 16'h0;
        for (int i = 0; i < 8; i++)
            if (tri_controller_OH[i]) busVal = dpR[i];
        if (tri_controller_OH[9])  busVal = dpG;
        if (tri_controller_OH[10]) busVal = code[15:0];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (r_en_OH[i]) dpR[i] <= busVal;
        if (r_en_OH[10]) dpA <= busVal;
        if (r_en_OH[9])  dpG <= dpAlu(dpA, busVal, code[22:20]);
    end

    // Bus contention watch, sampled every cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            vecCount++;
            if (!$onehot0(tri_controller_OH)) begin
                missCount++;
                $display("[TB] FAIL busContention: tri_controller_OH=%h required at most one bit", tri_controller_OH);
            end
        end
    end

    // Reference register file, updated one whole instruction at a time.
    logic [15:0] refRegs [8] = '{default: 16'h0};

    function automatic logic [15:0] refExec(input logic [2:0] op, input logic [15:0] x,
                                            input logic [15:0] y, input logic [15:0] imm);
        case (op)
            3'd0:    return y;
            3'd1:    return imm;
            3'd2:    return x + y;
            3'd3:    return x - y;
            3'd4:    return x & y;
            3'd5:    return x | y;
            3'd6:    return x ^ y;
            default: return x;
        endcase
    endfunction

    typedef struct packed {
        logic [19:0] ren;
        logic [19:0] drv;
        logic [22:0] cd;
        logic        dn;
        logic        rdy;
        logic        hlt;
    } ctrl_t;

    // Expected control word per phase: 0 idle, 1..3 = T1..T3, 5 halted.
    function automatic ctrl_t expectCtrl(input logic [2:0] op, input logic [2:0] rx,
                                         input logic [2:0] ry, input logic [15:0] imm,
                                         input int phase);
        ctrl_t e;
        e = '0;
        if (phase == 0) e.rdy = 1'b1;
        else if (phase == 5) e.hlt = 1'b1;
        else if (op == 3'd0 && phase == 1) begin
            e.drv[ry] = 1'b1; e.ren[rx] = 1'b1; e.dn = 1'b1;
        end else if (op == 3'd1 && phase == 1) begin
            e.drv[10] = 1'b1; e.cd[15:0] = imm; e.ren[rx] = 1'b1; e.dn = 1'b1;
        end else if (op >= 3'd2 && op <= 3'd6) begin
            if (phase == 1) begin
                e.drv[rx] = 1'b1; e.ren[10] = 1'b1;
            end else if (phase == 2) begin
                e.drv[ry] = 1'b1; e.ren[9] = 1'b1; e.cd[22:20] = op - 3'd2;
            end else if (phase == 3) begin
                e.drv[9] = 1'b1; e.ren[rx] = 1'b1; e.dn = 1'b1;
            end else e.rdy = 1'b1;
        end else e.rdy = 1'b1;
        return e;
    endfunction

    task automatic checkOutput(input string name, input ctrl_t exp);
        ctrl_t act;
        act = {r_en_OH, tri_controller_OH, code, done, instr_ready, halted};
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got ren=%h tri=%h code=%h done=%b rdy=%b hlt=%b, required ren=%h tri=%h code=%h done=%b rdy=%b hlt=%b",
                     name, act.ren, act.drv, act.cd, act.dn, act.rdy, act.hlt,
                     exp.ren, exp.drv, exp.cd, exp.dn, exp.rdy, exp.hlt);
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Issues one instruction, checks every cycle's controls, and returns the
    // number of cycles from the accept edge to the write-back edge (0 = never done).
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rx,
                                 input logic [2:0] ry, input logic [15:0] imm,
                                 input bit junk, output int lat);
        int waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("idleBeforeAccept", expectCtrl(op, rx, ry, imm, 0));
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rx    = rx;
        instr_ry    = ry;
        instr_imm   = imm;
        lat = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            instr_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            instr_op    = 3'($urandom_range(0, 7));
            instr_rx    = 3'($urandom_range(0, 7));
            instr_ry    = 3'($urandom_range(0, 7));
            instr_imm   = 16'($urandom);
            checkOutput($sformatf("op%0d_T%0d", op, n), expectCtrl(op, rx, ry, imm, n));
            if (done) begin
                lat = n;
                break;
            end
        end
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rx;
        logic [2:0]  ry;
        logic [15:0] imm;
        logic [15:0] expVal;
        logic [15:0] expA;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int lat;
        logic [2:0]  op, rx, ry;
        logic [15:0] imm;
        logic [15:0] saved;

        tbl[0] = '{3'd1, 3'd1, 3'd0, 16'h0005, 16'h0005, 16'h0000};
        tbl[1] = '{3'd1, 3'd2, 3'd0, 16'h0003, 16'h0003, 16'h0000};
        tbl[2] = '{3'd0, 3'd0, 3'd1, 16'h0000, 16'h0005, 16'h0000};
        tbl[3] = '{3'd2, 3'd1, 3'd2, 16'h0000, 16'h0008, 16'h0005};
        tbl[4] = '{3'd3, 3'd2, 3'd1, 16'h0000, 16'hFFFB, 16'h0003};
        tbl[5] = '{3'd6, 3'd1, 3'd1, 16'h0000, 16'h0000, 16'h0008};
        tbl[6] = '{3'd1, 3'd7, 3'd0, 16'hA5C3, 16'hA5C3, 16'h0000};
        tbl[7] = '{3'd5, 3'd7, 3'd2, 16'h0000, 16'hFFFB, 16'hA5C3};
        tbl[8] = '{3'd4, 3'd7, 3'd0, 16'h0000, 16'h0001, 16'hFFFB};
        tbl[9] = '{3'd1, 3'd3, 3'd0, 16'h4001, 16'h4001, 16'h0000};

        // Reset state.
        repeat (2) @(negedge clk);
        vecCount++;
        if ({r_en_OH, tri_controller_OH, code, done, halted} !== '0) begin
            missCount++;
            $display("[TB] FAIL resetOutputs: got ren=%h tri=%h code=%h done=%b hlt=%b required all 0",
                     r_en_OH, tri_controller_OH, code, done, halted);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("afterReset", expectCtrl(3'd0, 3'd0, 3'd0, 16'h0, 0));

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].op, tbl[i].rx, tbl[i].ry, tbl[i].imm, 1'b0, lat);
            checkVal($sformatf("tbl%0d_latency", i), 32'(lat), (tbl[i].op <= 3'd1) ? 32'd1 : 32'd3);
            checkVal($sformatf("tbl%0d_R%0d", i, tbl[i].rx), 32'(dpR[tbl[i].rx]), 32'(tbl[i].expVal));
            if (tbl[i].op >= 3'd2) begin
                checkVal($sformatf("tbl%0d_A", i), 32'(dpA), 32'(tbl[i].expA));
                checkVal($sformatf("tbl%0d_G", i), 32'(dpG), 32'(tbl[i].expVal));
            end
            refRegs[tbl[i].rx] = refExec(tbl[i].op, refRegs[tbl[i].rx], refRegs[tbl[i].ry], tbl[i].imm);
        end

        // rx == ry doubles the register.
        applyStimulus(3'd2, 3'd3, 3'd3, 16'h0, 1'b0, lat);
        checkVal("addR3R3", 32'(dpR[3]), 32'h8002);
        refRegs[3] = refExec(3'd2, refRegs[3], refRegs[3], 16'h0);

        // Reset during T2 of an ADD abandons it without touching the destination.
        saved = dpR[1];
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'd2; instr_rx = 3'd1; instr_ry = 3'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("midAdd_T2", expectCtrl(3'd2, 3'd1, 3'd2, 16'h0, 2));
        rst_n = 1'b0;
        #1;
        vecCount++;
        if ({r_en_OH, tri_controller_OH, code, done} !== '0) begin
            missCount++;
            $display("[TB] FAIL resetMidAdd: got ren=%h tri=%h code=%h done=%b required all 0",
                     r_en_OH, tri_controller_OH, code, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("resetMidAdd_R1", 32'(dpR[1]), 32'(saved));
        checkOutput("resetMidAdd_idle", expectCtrl(3'd0, 3'd0, 3'd0, 16'h0, 0));
        applyStimulus(3'd1, 3'd4, 3'd0, 16'h1234, 1'b0, lat);
        checkVal("postResetMvi_latency", 32'(lat), 32'd1);
        checkVal("postResetMvi_R4", 32'(dpR[4]), 32'h1234);
        refRegs[4] = 16'h1234;

        // Random instructions with junk valid pulses while busy.
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 6));
            rx  = 3'($urandom_range(0, 7));
            ry  = 3'($urandom_range(0, 7));
            imm = 16'($urandom);
            applyStimulus(op, rx, ry, imm, 1'b1, lat);
            refRegs[rx] = refExec(op, refRegs[rx], refRegs[ry], imm);
            checkVal($sformatf("rnd%0d_latency", i), 32'(lat), (op <= 3'd1) ? 32'd1 : 32'd3);
            checkVal($sformatf("rnd%0d_R%0d", i, rx), 32'(dpR[rx]), 32'(refRegs[rx]));
            if (i % 15 == 14)
                for (int r = 0; r < 8; r++)
                    checkVal($sformatf("rnd%0d_allR%0d", i, r), 32'(dpR[r]), 32'(refRegs[r]));
        end

        // HALT with valid held high: stays halted with no activity until reset.
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'd7; instr_rx = 3'd2; instr_ry = 3'd5;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            instr_op = (n % 2 == 0) ? 3'd7 : 3'd1;
            checkOutput($sformatf("halt_cycle%0d", n), expectCtrl(3'd7, 3'd0, 3'd0, 16'h0, 5));
        end
        for (int r = 0; r < 8; r++)
            checkVal($sformatf("halt_R%0d", r), 32'(dpR[r]), 32'(refRegs[r]));
        instr_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("afterHaltReset", expectCtrl(3'd0, 3'd0, 3'd0, 16'h0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
